// File: rtl/tx_memory_pkg.sv
// Shared motor-control definitions: frame sync word, transmit/receive FSM state
// encoding and the clock/reset bundle used by tx_memory and rx_memory.
package MCPkg;

  localparam int          NUMBER_OF_MOTORS_PER_FIBER = 16;
  localparam logic [15:0] TXMEM_SYNC_WORD            = 16'hA55A;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    DATA_HI  = 3'd2,
    DATA_LO  = 3'd3,
    CHECKSUM = 3'd4
  } tx_state_t;

  typedef struct packed {
    logic clk;
    logic reset;
  } t_clk_rs;

endpackage

// File: rtl/tx_memory.sv
// Serialises g_pages 32-bit pages into a 16-bit GBT slot stream framed by a sync word.
// Define TX_MEMORY_CHECKSUM_EN to append a 16-bit modulo sum of the data words.
module tx_memory
  import MCPkg::*;
#(
  parameter int          g_pages     = NUMBER_OF_MOTORS_PER_FIBER,
  parameter logic [15:0] g_sync_word = TXMEM_SYNC_WORD
) (
  input  t_clk_rs     ClkRs_ix,
  input  logic        start_i,
  input  logic        slot_i,
  output logic [7:0]  page_ob,
  input  logic [31:0] data_ib32,
  output logic [15:0] data_ob16,
  output logic        data_valid_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic        busy_o,
  output logic        start_lost_o,
  output tx_state_t   state_o
);

  // Handshake: slot_i is a strobe with no back-pressure; each slot_i seen in a
  // non-idle state yields exactly one data_valid_o pulse on the following cycle.

  localparam logic [7:0] LAST_PAGE = 8'(g_pages - 1);

  logic clk;
  logic reset;
  assign clk   = ClkRs_ix.clk;
  assign reset = ClkRs_ix.reset;

  tx_state_t   state, state_nx;
  logic [15:0] hold, hold_nx;
  logic [7:0]  page, page_nx;
  logic [15:0] data, data_nx;
  logic        valid_nx, sof_nx, eof_nx, lost_nx;
  logic        valid, sof, eof, lost;
`ifdef TX_MEMORY_CHECKSUM_EN
  logic [15:0] sum, sum_nx;
`endif

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    page_nx  = page;
    data_nx  = data;
    valid_nx = 1'b0;
    sof_nx   = 1'b0;
    eof_nx   = 1'b0;
    lost_nx  = start_i && (state != IDLE);
`ifdef TX_MEMORY_CHECKSUM_EN
    sum_nx   = sum;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nx = SYNC;
          page_nx  = 8'd0;
`ifdef TX_MEMORY_CHECKSUM_EN
          sum_nx   = 16'd0;
`endif
        end
      end
      SYNC: begin
        if (slot_i) begin
          data_nx  = g_sync_word;
          valid_nx = 1'b1;
          sof_nx   = 1'b1;
          state_nx = DATA_HI;
        end
      end
      DATA_HI: begin
        if (slot_i) begin
          hold_nx  = data_ib32[15:0];
          data_nx  = data_ib32[31:16];
          valid_nx = 1'b1;
          state_nx = DATA_LO;
`ifdef TX_MEMORY_CHECKSUM_EN
          sum_nx   = sum + data_ib32[31:16];
`endif
        end
      end
      DATA_LO: begin
        if (slot_i) begin
          data_nx  = hold;
          valid_nx = 1'b1;
`ifdef TX_MEMORY_CHECKSUM_EN
          sum_nx   = sum + hold;
`endif
          if (page == LAST_PAGE) begin
`ifdef TX_MEMORY_CHECKSUM_EN
            state_nx = CHECKSUM;
`else
            eof_nx   = 1'b1;
            state_nx = IDLE;
`endif
          end else begin
            // Page advances as the low half leaves; the mux has until the next slot to settle.
            page_nx  = page + 8'd1;
            state_nx = DATA_HI;
          end
        end
      end
`ifdef TX_MEMORY_CHECKSUM_EN
      CHECKSUM: begin
        if (slot_i) begin
          data_nx  = sum;
          valid_nx = 1'b1;
          eof_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold  <= 16'd0;
      page  <= 8'd0;
      data  <= 16'd0;
      valid <= 1'b0;
      sof   <= 1'b0;
      eof   <= 1'b0;
      lost  <= 1'b0;
`ifdef TX_MEMORY_CHECKSUM_EN
      sum   <= 16'd0;
`endif
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      page  <= page_nx;
      data  <= data_nx;
      valid <= valid_nx;
      sof   <= sof_nx;
      eof   <= eof_nx;
      lost  <= lost_nx;
`ifdef TX_MEMORY_CHECKSUM_EN
      sum   <= sum_nx;
`endif
    end
  end

  // busy_o drops on the same edge that raises eof_o because the FSM is back in IDLE.
  assign busy_o       = (state != IDLE);
  assign page_ob      = page;
  assign data_ob16    = data;
  assign data_valid_o = valid;
  assign sof_o        = sof;
  assign eof_o        = eof;
  assign start_lost_o = lost;
  assign state_o      = state;

endmodule

// File: tb/tb_tx_memory.sv
// Directed bench for tx_memory: a 2-page instance driven from a vector table and
// hand sequences, plus a 16-page instance fed random pages and slot spacing.
module tb_tx_memory;
  import MCPkg::*;

`ifdef TX_MEMORY_CHECKSUM_EN
  localparam bit CS_ON = 1'b1;
`else
  localparam bit CS_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  t_clk_rs clk_rs;
  assign clk_rs.clk   = clk;
  assign clk_rs.reset = reset;

  logic sel = 1'b0;
  logic start = 1'b0;
  logic slot = 1'b0;

  logic        start_a, slot_a, start_b, slot_b;
  logic [7:0]  page_a, page_b;
  logic [31:0] din_a, din_b;
  logic [15:0] dout_a, dout_b;
  logic        dv_a, sof_a, eof_a, busy_a, lost_a;
  logic        dv_b, sof_b, eof_b, busy_b, lost_b;
  tx_state_t   st_a, st_b;

  assign start_a = start & ~sel;
  assign slot_a  = slot & ~sel;
  assign start_b = start & sel;
  assign slot_b  = slot & sel;

  logic [31:0] pages_a [2];
  logic [31:0] pages_b [16];

  // external registered page mux
  always_ff @(posedge clk) begin
    din_a <= pages_a[page_a[0]];
    din_b <= pages_b[page_b[3:0]];
  end

  tx_memory #(.g_pages(2)) dut_a (
    .ClkRs_ix(clk_rs), .start_i(start_a), .slot_i(slot_a), .page_ob(page_a),
    .data_ib32(din_a), .data_ob16(dout_a), .data_valid_o(dv_a), .sof_o(sof_a),
    .eof_o(eof_a), .busy_o(busy_a), .start_lost_o(lost_a), .state_o(st_a)
  );

  tx_memory #(.g_pages(16)) dut_b (
    .ClkRs_ix(clk_rs), .start_i(start_b), .slot_i(slot_b), .page_ob(page_b),
    .data_ib32(din_b), .data_ob16(dout_b), .data_valid_o(dv_b), .sof_o(sof_b),
    .eof_o(eof_b), .busy_o(busy_b), .start_lost_o(lost_b), .state_o(st_b)
  );

  logic [7:0]  page;
  logic [15:0] dout;
  logic        dv, sof, eof, busy, lost;
  assign page = sel ? page_b : page_a;
  assign dout = sel ? dout_b : dout_a;
  assign dv   = sel ? dv_b   : dv_a;
  assign sof  = sel ? sof_b  : sof_a;
  assign eof  = sel ? eof_b  : eof_a;
  assign busy = sel ? busy_b : busy_a;
  assign lost = sel ? lost_b : lost_a;

  // scoreboard
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int lost_cnt = 0;
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    if (dv) got_q.push_back({eof, sof, dout});
    if (lost) lost_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] page_word(input int p);
    return sel ? pages_b[p] : pages_a[p];
  endfunction

  // driver tasks
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic slot_pulse(input int gap);
    @(posedge clk); #1 slot = 1'b1;
    @(posedge clk); #1 slot = 1'b0;
    check("word_latency", {31'd0, dv}, 32'd1);
    check("busy_vs_eof", {31'd0, busy}, {31'd0, !eof});
    @(posedge clk); #1;
    check("valid_one_cycle", {31'd0, dv}, 32'd0);
    repeat (gap - 3) @(posedge clk);
  endtask

  // mode 0: plain frame; 1: extra start during the third data word; 2: start with slot
  task automatic run_frame(input int np, input logic [15:0] cs, input int glo,
                           input int ghi, input int mode);
    logic [31:0] pw;
    int nw;
    int lost0;
    int n;
    got_q.delete();
    exp_q.delete();
    exp_q.push_back({2'b01, TXMEM_SYNC_WORD});
    for (int p = 0; p < np; p++) begin
      pw = page_word(p);
      exp_q.push_back({2'b00, pw[31:16]});
      exp_q.push_back({(p == np - 1) && !CS_ON, 1'b0, pw[15:0]});
    end
    if (CS_ON) exp_q.push_back({2'b10, cs});
    nw = exp_q.size();
    lost0 = lost_cnt;

    if (mode == 2) begin
      @(posedge clk); #1 start = 1'b1; slot = 1'b1;
      @(posedge clk); #1 start = 1'b0; slot = 1'b0;
      check("same_cycle_no_word", {31'd0, dv}, 32'd0);
    end else begin
      pulse_start();
    end
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_page", {24'd0, page}, 32'd0);

    for (int i = 0; i < nw; i++) begin
      if (mode == 1 && i == 4) begin
        pulse_start();
        check("start_lost_pulse", {31'd0, lost}, 32'd1);
      end
      slot_pulse($urandom_range(ghi, glo));
    end
    repeat (2) @(posedge clk); #1;
    check("end_busy", {31'd0, busy}, 32'd0);
    check("end_page", {24'd0, page}, 32'(np - 1));
    check("data_hold", {16'd0, dout}, {16'd0, exp_q[nw - 1][15:0]});
    check("lost_count", lost_cnt, (mode == 1) ? lost0 + 1 : lost0);
    check("word_count", got_q.size(), nw);
    n = (got_q.size() < nw) ? got_q.size() : nw;
    for (int i = 0; i < n; i++) check($sformatf("word_%0d", i), {14'd0, got_q[i]}, {14'd0, exp_q[i]});
  endtask

  typedef struct {
    logic [31:0] p0;
    logic [31:0] p1;
    logic [15:0] cs;
    int          gap;
  } vec_t;

  vec_t vecs[4];
  logic [15:0] sum;
  int eofs;

  initial begin
    vecs[0] = '{32'h11112222, 32'h33334444, 16'hAAAA, 4};
    vecs[1] = '{32'hFFFFFFFF, 32'h00020000, 16'h0000, 3};
    vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 16'hE258, 5};
    vecs[3] = '{32'h00000000, 32'h00000001, 16'h0001, 3};
    pages_a[0] = 32'd0;
    pages_a[1] = 32'd0;
    for (int p = 0; p < 16; p++) pages_b[p] = 32'd0;

    // reset with start held: must be ignored
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0; reset = 1'b0;
    check("rst_dout", {16'd0, dout_a}, 32'd0);
    check("rst_page", {24'd0, page_a}, 32'd0);
    check("rst_flags", {27'd0, dv_a, sof_a, eof_a, busy_a, lost_a}, 32'd0);
    check("rst_flags_b", {27'd0, dv_b, sof_b, eof_b, busy_b, lost_b}, 32'd0);
    repeat (2) @(posedge clk); #1;
    check("rst_start_ignored", {31'd0, busy_a}, 32'd0);

    // table-driven frames on the 2-page instance
    for (int i = 0; i < 4; i++) begin
      pages_a[0] = vecs[i].p0;
      pages_a[1] = vecs[i].p1;
      run_frame(2, vecs[i].cs, vecs[i].gap, vecs[i].gap, 0);
    end

    // start while busy is dropped
    pages_a[0] = vecs[0].p0;
    pages_a[1] = vecs[0].p1;
    run_frame(2, vecs[0].cs, 4, 4, 1);

    // reset after the second data word
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) slot_pulse(4);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_dout", {16'd0, dout_a}, 32'd0);
    check("mid_rst_page", {24'd0, page_a}, 32'd0);
    check("mid_rst_flags", {27'd0, dv_a, sof_a, eof_a, busy_a, lost_a}, 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    eofs = 0;
    foreach (got_q[i]) if (got_q[i][17]) eofs++;
    check("mid_rst_no_eof", eofs, 0);
    check("mid_rst_words", got_q.size(), 3);
    run_frame(2, vecs[0].cs, 4, 4, 0);

    // start and slot in the same cycle
    pages_a[0] = vecs[2].p0;
    pages_a[1] = vecs[2].p1;
    run_frame(2, vecs[2].cs, 3, 3, 2);

    // 16-page instance: random pages and slot spacing
    sel = 1'b1;
    for (int f = 0; f < 2; f++) begin
      sum = 16'd0;
      for (int p = 0; p < 16; p++) begin
        pages_b[p] = $urandom;
        sum = sum + pages_b[p][31:16] + pages_b[p][15:0];
      end
      run_frame(16, sum, 3, 10, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_memory.md
TX_MEMORY -- requirements
Module: tx_memory

Interface
REQ-001 SHALL have parameter g_pages, default NUMBER_OF_MOTORS_PER_FIBER (16), the number of 32-bit pages per frame, legal range 1..256.
REQ-002 SHALL have parameter g_sync_word, default TXMEM_SYNC_WORD (16'hA55A), the frame header word.
REQ-003 SHALL use one clock and a synchronous, active-high reset, delivered on ClkRs_ix as listed below.
REQ-004 ClkRs_ix.clk  input  1  sole clock.
REQ-005 ClkRs_ix.reset  input  1  synchronous active-high reset.
REQ-006 start_i  input  1  single-cycle frame request.
REQ-007 slot_i  input  1  GBT slot strobe; one word is emitted per accepted slot; pulses are at least 3 cycles apart.
REQ-008 page_ob  output  8  page address to the external registered page mux.
REQ-009 data_ib32  input  32  page content, valid from the second cycle after page_ob changes.
REQ-010 data_ob16  output  16  stream word.
REQ-011 data_valid_o  output  1  data_ob16 qualifier, one-cycle pulse.
REQ-012 sof_o / eof_o  output  1 each  first-word / last-word markers, coincident with data_valid_o.
REQ-013 busy_o  output  1  high while a frame is in progress.
REQ-014 start_lost_o  output  1  one-cycle pulse when a start_i is rejected.

Function
REQ-015 SHALL implement FSM IDLE -> SYNC -> DATA_HI -> DATA_LO -> (DATA_HI for the next page | CHECKSUM | IDLE).
REQ-016 IDLE: start_i -> SYNC on the next cycle, set busy_o, set page_ob=0; slot_i in IDLE is ignored.
REQ-017 A slot_i in the same cycle as an accepted start_i SHALL NOT be used; SYNC emits on the next slot_i.
REQ-018 Each state emits on slot_i; the word appears on data_ob16 with data_valid_o=1 exactly one cycle after slot_i (latency 1).
REQ-019 SYNC SHALL emit g_sync_word with sof_o=1.
REQ-020 DATA_HI SHALL capture data_ib32 into a hold register and emit [31:16].
REQ-021 DATA_LO SHALL emit hold[15:0], then increment page_ob on the following cycle.
REQ-022 Page order SHALL be 0..g_pages-1, high half before low half, giving 2*g_pages data words per frame.
REQ-023 The last word of the frame (last DATA_LO, or CHECKSUM when compiled in) SHALL carry eof_o=1, after which the FSM returns to IDLE and busy_o falls in the same cycle as eof_o.
REQ-024 start_i while busy_o=1 SHALL be dropped, pulse start_lost_o the next cycle, and leave the frame undisturbed.
REQ-025 data_ob16 SHALL hold its last value between pulses; data_valid_o, sof_o and eof_o are high for exactly one cycle per word.
REQ-026 page_ob SHALL remain at g_pages-1 after a frame and wrap to 0 only on the next accepted start.

Reset
REQ-027 Reset SHALL force IDLE, abandon any partial frame without emitting eof_o, and clear the checksum accumulator.
REQ-028 Reset SHALL set data_ob16=0, page_ob=0, and data_valid_o, sof_o, eof_o, busy_o, start_lost_o to 0.
REQ-029 start_i during reset SHALL be ignored.

Configuration
REQ-030 Macro TX_MEMORY_CHECKSUM_EN defined: a CHECKSUM state follows the last DATA_LO and emits, on the next slot_i, the 16-bit sum modulo 2^16 of all data words (sync word excluded); the frame is 2*g_pages+2 words.
REQ-031 Macro undefined: no CHECKSUM state and no accumulator; eof_o is on the last DATA_LO; the frame is 2*g_pages+1 words.

Structure
REQ-032 TXMEM_SYNC_WORD and the FSM state enum SHALL reside in MCPkg, shared with rx_memory.
REQ-033 The block SHALL be a single module with no sub-module; the page mux is external.

Verification
REQ-034 g_pages=2, pages 0x11112222 / 0x33334444, start, slot every 4 cycles -> A55A(sof), 1111, 2222, 3333, 4444, then AAAA(eof) with the macro, or 4444 carrying eof without it.
REQ-035 Macro on, pages 0xFFFFFFFF / 0x00020000 -> checksum word 0x0000 (modulo wrap).
REQ-036 start_i during the third data word -> start_lost_o pulses once, and the frame completes unchanged.
REQ-037 Reset asserted after the second data word -> all outputs 0 the next cycle, no eof_o; a new start then yields a complete frame beginning A55A.
REQ-038 start_i and slot_i in the same cycle -> no output that cycle; A55A appears one cycle after the next slot_i.
REQ-039 g_pages=16, random pages, random slot spacing of 3 to 10 cycles -> scoreboard matches all 33 (or 34 with the macro) words and their order; busy_o falls with eof_o.
